// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with locked-transfer and fixed-burst grant hold.
// Defining AHB_ARB_SPLIT_EN enables SPLIT masking; otherwise SPLIT is handled like RETRY.
// state | meaning
// ARB   | free to re-arbitrate on HREADY edges
// BURST | fixed-length burst in progress, grant held
// LOCK  | granted master holds the bus for a locked sequence
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   clock,
    input  logic                   Rst,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    input  logic [15:0]            HSPLITx,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);

    typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_LOCK} state_t;

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;
    localparam logic [NUM_MASTERS-1:0] ONE       = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = ONE << DEFAULT_MASTER;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_cnt, w_cnt_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [3:0]             r_last, w_last_nxt;
    logic [3:0]             r_master;
    logic                   r_mastlock;

    logic [3:0]             w_gidx;
    logic [3:0]             w_load;
    logic                   w_fixed;
    logic                   w_arb;
    logic                   w_retry_like;
    logic                   w_own_lock, w_own_req, w_own_split;
    logic                   w_early_end;
    logic                   w_retain;
    logic [NUM_MASTERS-1:0] w_split_set, w_mask_nxt, w_elig;
    logic                   w_unused;

`ifdef AHB_ARB_SPLIT_EN
    logic [NUM_MASTERS-1:0] r_split_mask;

    // Release beats a simultaneous SPLIT of the same master.
    always_comb begin
        w_split_set = '0;
        for (int k = 0; k < NUM_MASTERS; k++)
            w_split_set[k] = HREADY && (HRESP == RESP_SPLIT) && (r_master == 4'(k));
    end
    assign w_mask_nxt   = (r_split_mask | w_split_set) & ~HSPLITx[NUM_MASTERS-1:0];
    assign w_retry_like = (HRESP == RESP_RETRY);

    always_ff @(posedge clock) begin
        if (Rst) r_split_mask <= '0;
        else     r_split_mask <= w_mask_nxt;
    end
`else
    assign w_split_set  = '0;
    assign w_mask_nxt   = '0;
    assign w_retry_like = (HRESP == RESP_RETRY) || (HRESP == RESP_SPLIT);
`endif

    assign w_unused    = ^HSPLITx;
    assign w_elig      = HBUSREQx & ~w_mask_nxt;
    assign w_own_lock  = |(HLOCKx & r_grant);
    assign w_own_req   = |(HBUSREQx & r_grant);
    assign w_own_split = |(w_split_set & r_grant);
    assign w_early_end = (HTRANS == TR_IDLE) || (HRESP != RESP_OKAY);
    assign w_retain    = w_retry_like && |(r_grant & w_elig);

    always_comb begin
        w_gidx = '0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (r_grant[k]) w_gidx = 4'(k);
    end

    always_comb begin
        w_fixed = 1'b1;
        case (HBURST)
            3'b010, 3'b011: w_load = 4'd3;
            3'b100, 3'b101: w_load = 4'd7;
            3'b110, 3'b111: w_load = 4'd15;
            default: begin
                w_load  = 4'd0;
                w_fixed = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (Rst) begin
            r_state    <= ST_ARB;
            r_cnt      <= '0;
            r_grant    <= DEF_GRANT;
            r_last     <= 4'(DEFAULT_MASTER);
            r_master   <= 4'(DEFAULT_MASTER);
            r_mastlock <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            if (HREADY) begin
                r_master   <= w_gidx;
                r_mastlock <= w_own_lock;
            end
        end
    end

    always_comb begin : p_next
        int best_d;
        int d;
        int win;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_arb       = 1'b0;
        best_d      = NUM_MASTERS;
        d           = 0;
        win         = DEFAULT_MASTER;
        if (HREADY) begin
            if (r_state == ST_LOCK) begin
                if (!w_own_lock || w_own_split) w_state_nxt = ST_ARB;
            end else if (w_own_lock && w_own_req && !w_own_split) begin
                w_state_nxt = ST_LOCK;
                w_cnt_nxt   = '0;
            end else if (r_state == ST_BURST) begin
                if (w_early_end) begin
                    w_state_nxt = ST_ARB;
                    w_cnt_nxt   = '0;
                end else if (HTRANS == TR_SEQ) begin
                    // Leave on the penultimate beat so the next grant is set up during the last address.
                    if (r_cnt == 4'd2) begin
                        w_state_nxt = ST_ARB;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end else if (HTRANS == TR_NONSEQ && w_fixed && HRESP == RESP_OKAY) begin
                w_state_nxt = ST_BURST;
                w_cnt_nxt   = w_load;
            end else begin
                w_arb = 1'b1;
            end
        end
        if (w_arb && !w_retain) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                d = (k + NUM_MASTERS - int'(r_last) - 1) % NUM_MASTERS;
                if (w_elig[k] && d < best_d) begin
                    best_d = d;
                    win    = k;
                end
            end
            if (best_d < NUM_MASTERS) begin
                w_grant_nxt = ONE << win;
                w_last_nxt  = 4'(win);
            end else begin
                w_grant_nxt = DEF_GRANT;
            end
        end
    end

    always_comb begin
        HGRANTx   = r_grant;
        HMASTER   = r_master;
        HMASTLOCK = r_mastlock;
    end

endmodule
